rv32_alu: RTL and testbench
===========================

// Module: rv32_alu
// PURPOSE
//   RV32I integer ALU for the execute stage of the riscy_core pipeline.
//   Takes two register operands plus the funct3/funct7 selector of an
//   R-type instruction and performs ADD/SUB, shifts, compares or logic ops.
//   Result and zero flag are registered, giving one cycle of latency.
// PARAMETERS
//   XLEN  32  operand/result width; shift amount is rs2[$clog2(XLEN)-1:0]
// PORTS
//   clk     in   1     clock, rising edge active
//   rst     in   1     asynchronous, active-high reset
//   rs1     in   XLEN  operand A
//   rs2     in   XLEN  operand B (shift amount in low 5 bits)
//   funct3  in   3     operation select (RISC-V funct3)
//   funct7  in   1     funct7[5] of the instruction: SUB/SRA modifier
//   rd      out  XLEN  registered result
//   z       out  1     registered zero flag: 1 iff next rd value == 0
// BEHAVIOUR
//   One clock; reset is asynchronous and active-high.
//   - rst=1: rd<=0 and z<=0 immediately, regardless of clk; held while rst=1.
//   - Each rising clk with rst=0: rd<=f(rs1,rs2,funct3,funct7); z<=(f==0).
//   - Latency: exactly 1 cycle; new operands every cycle, no handshake.
//   - Operation table (funct3 / funct7):
//       000/0 ADD   rs1+rs2, modulo 2^XLEN (carry discarded)
//       000/1 SUB   rs1-rs2, modulo 2^XLEN (borrow wraps, e.g. 3-8=FFFFFFFB)
//       001/x SLL   rs1 << rs2[4:0]
//       010/x SLT   signed rs1<rs2 ? 1 : 0 (zero-extended to XLEN)
//       011/x SLTU  unsigned rs1<rs2 ? 1 : 0
//       100/x XOR   rs1 ^ rs2
//       101/0 SRL   rs1 >> rs2[4:0], zero fill
//       101/1 SRA   rs1 >>> rs2[4:0], sign fill from rs1[XLEN-1]
//       110/x OR    rs1 | rs2
//       111/x AND   rs1 & rs2
//   - funct7 is ignored for every funct3 except 000 and 101.
//   - Shift amount uses only rs2[4:0]; rs2[31:5] ignored (shift by 32 = by 0).
//   - No overflow flag; signed overflow on ADD/SUB wraps silently.
//   - z reflects the full XLEN-bit result of every op, including SLT/SLTU.
//   - Reset deasserted mid-stream: first capture on the next rising edge.
// TESTING
//   1. rst pulse mid-cycle while rd=0x32 -> rd=0, z=0 at once, no clk edge.
//   2. ADD 20+30 -> rd=50 next edge; SUB 8-3 -> 5; SUB 20-20 -> rd=0, z=1.
//   3. SLL 8<<3 -> 64; SRL 8>>3 -> 1; SRA 0x80000000>>>4 -> 0xF8000000;
//      rs2=0x23 shifts by 3.
//   4. SLT 8,3 -> 0; SLT 0xFFFFFFFF(-1),1 -> 1; SLTU 0xFFFFFFFF,1 -> 0.
//   5. XOR 8^3 -> 11; OR 20|30 -> 30; AND 20&30 -> 20; funct7=1 unchanged.
//   6. Back-to-back ops on consecutive cycles -> each rd one cycle later;
//      ADD 0xFFFFFFFF+1 -> rd=0, z=1.

Source files
------------

// File: rtl/rv32_alu_if.sv
// rv32_alu_if: operand/result bundle between the execute stage and the ALU.
//   rs1, rs2  operands A and B (rs2 low bits also carry the shift amount)
//   funct3    RISC-V funct3 operation select
//   funct7    funct7[5] of the instruction (SUB/SRA modifier)
//   rd, z     registered result and zero flag, one cycle after the operands
// Handshake: none. There is no valid/ready pair. The master presents a new
// operation on every cycle, and the slave captures it on every rising clock
// edge, so results stream out one-for-one with exactly one cycle of delay.
interface rv32_alu_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [2:0]      funct3;
  logic            funct7;
  logic [XLEN-1:0] rd;
  logic            z;

  modport master (
    output rs1, rs2, funct3, funct7,
    input  rd, z
  );

  modport slave (
    input  rs1, rs2, funct3, funct7,
    output rd, z
  );
endinterface

// File: rtl/rv32_alu.sv
// rv32_alu: RV32I integer ALU for the riscy_core execute stage.
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset (clears rd and z)
//   bus   rv32_alu_if slave: rs1/rs2/funct3/funct7 in, rd/z out
// The ALU computes ADD/SUB, SLL/SRL/SRA, SLT/SLTU, XOR, OR or AND
// combinationally. It registers the result together with its zero flag,
// which gives a fixed latency of one cycle.
module rv32_alu #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  rv32_alu_if.slave   bus
);
  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] result;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] rd_q;
  logic            z_q;

  // Only the low SHW bits select the shift distance, so a shift by XLEN
  // aliases to a shift by 0.
  assign shamt = bus.rs2[SHW-1:0];

  always_comb begin
    result = '0;
    case (bus.funct3)
      3'b000: result = bus.funct7 ? (bus.rs1 - bus.rs2) : (bus.rs1 + bus.rs2);
      3'b001: result = bus.rs1 << shamt;
      3'b010: result = {{(XLEN-1){1'b0}}, ($signed(bus.rs1) < $signed(bus.rs2))};
      3'b011: result = {{(XLEN-1){1'b0}}, (bus.rs1 < bus.rs2)};
      3'b100: result = bus.rs1 ^ bus.rs2;
      // The arithmetic shift is done on a signed view so that the sign bit
      // fills from rs1[XLEN-1].
      3'b101: result = bus.funct7 ? $unsigned($signed(bus.rs1) >>> shamt)
                                  : (bus.rs1 >> shamt);
      3'b110: result = bus.rs1 | bus.rs2;
      3'b111: result = bus.rs1 & bus.rs2;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
      z_q  <= 1'b0;
    end else begin
      rd_q <= result;
      z_q  <= (result == '0);
    end
  end

  assign bus.rd = rd_q;
  assign bus.z  = z_q;
endmodule

// File: tb/tb_rv32_alu.sv
// tb_rv32_alu: directed vector bench for rv32_alu (one-cycle latency).
module tb_rv32_alu;
  localparam int XLEN = 32;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rv32_alu_if #(.XLEN(XLEN)) bus ();

  rv32_alu #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- vectors ----------------
  typedef struct {
    string           name;
    logic [2:0]      funct3;
    logic            funct7;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] exp_rd;
    logic            exp_z;
  } vec_t;

  vec_t vecs[$];

  int checks = 0;
  int passes = 0;

  // Scoreboard for streamed ops: {z, rd} expected one cycle after issue.
  logic [XLEN:0] exp_q[$];

  task automatic add_vec(input string name, input logic [2:0] f3, input logic f7,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] erd, input logic ez);
    vec_t v;
    v.name = name; v.funct3 = f3; v.funct7 = f7; v.rs1 = a; v.rs2 = b;
    v.exp_rd = erd; v.exp_z = ez;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [2:0] f3, input logic f7,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.rs1    = a;
    bus.rs2    = b;
  endtask

  // ---------------- test ----------------
  initial begin
    logic [XLEN:0] e;

    add_vec("add_20_30",    3'b000, 1'b0, 32'd20,        32'd30,        32'd50,        1'b0);
    add_vec("sub_8_3",      3'b000, 1'b1, 32'd8,         32'd3,         32'd5,         1'b0);
    add_vec("sub_20_20",    3'b000, 1'b1, 32'd20,        32'd20,        32'd0,         1'b1);
    add_vec("sub_3_8",      3'b000, 1'b1, 32'd3,         32'd8,         32'hFFFFFFFB,  1'b0);
    add_vec("add_wrap",     3'b000, 1'b0, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b1);
    add_vec("sll_8_3",      3'b001, 1'b0, 32'd8,         32'd3,         32'd64,        1'b0);
    add_vec("sll_rs2_23",   3'b001, 1'b0, 32'd8,         32'h23,        32'd64,        1'b0);
    add_vec("sll_f7",       3'b001, 1'b1, 32'd8,         32'd3,         32'd64,        1'b0);
    add_vec("srl_8_3",      3'b101, 1'b0, 32'd8,         32'd3,         32'd1,         1'b0);
    add_vec("srl_msb_4",    3'b101, 1'b0, 32'h80000000,  32'd4,         32'h08000000,  1'b0);
    add_vec("sra_msb_4",    3'b101, 1'b1, 32'h80000000,  32'd4,         32'hF8000000,  1'b0);
    add_vec("sra_by_32",    3'b101, 1'b1, 32'h80000000,  32'h20,        32'h80000000,  1'b0);
    add_vec("slt_8_3",      3'b010, 1'b0, 32'd8,         32'd3,         32'd0,         1'b1);
    add_vec("slt_m1_1",     3'b010, 1'b0, 32'hFFFFFFFF,  32'd1,         32'd1,         1'b0);
    add_vec("slt_min_max",  3'b010, 1'b1, 32'h80000000,  32'h7FFFFFFF,  32'd1,         1'b0);
    add_vec("sltu_m1_1",    3'b011, 1'b0, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b1);
    add_vec("sltu_1_m1",    3'b011, 1'b0, 32'd1,         32'hFFFFFFFF,  32'd1,         1'b0);
    add_vec("xor_8_3",      3'b100, 1'b0, 32'd8,         32'd3,         32'd11,        1'b0);
    add_vec("xor_f7",       3'b100, 1'b1, 32'd8,         32'd3,         32'd11,        1'b0);
    add_vec("xor_same",     3'b100, 1'b0, 32'hA5A5A5A5,  32'hA5A5A5A5,  32'd0,         1'b1);
    add_vec("or_20_30",     3'b110, 1'b0, 32'd20,        32'd30,        32'd30,        1'b0);
    add_vec("or_f7",        3'b110, 1'b1, 32'd20,        32'd30,        32'd30,        1'b0);
    add_vec("and_20_30",    3'b111, 1'b0, 32'd20,        32'd30,        32'd20,        1'b0);
    add_vec("and_f7",       3'b111, 1'b1, 32'd20,        32'd30,        32'd20,        1'b0);
    add_vec("and_zero",     3'b111, 1'b0, 32'hF0F0F0F0,  32'h0F0F0F0F,  32'd0,         1'b1);

    // Reset state
    rst = 1'b1;
    drive(3'b000, 1'b0, 32'd20, 32'd30);
    #12;
    check("reset_rd", bus.rd, 32'd0);
    check("reset_z",  {31'd0, bus.z}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset mid-cycle while rd holds 0x32
    @(posedge clk); #1;
    check("pre_rst_rd", bus.rd, 32'h32);
    #1 rst = 1'b1;
    #1;
    check("async_rst_rd", bus.rd, 32'd0);
    check("async_rst_z",  {31'd0, bus.z}, 32'd0);
    // Held through a clock edge while reset stays high
    @(posedge clk); #1;
    check("rst_hold_rd", bus.rd, 32'd0);
    // Release mid-stream: nothing is captured until the next rising edge
    @(negedge clk);
    rst = 1'b0;
    drive(3'b000, 1'b1, 32'd20, 32'd20);
    #1;
    check("rel_no_cap_rd", bus.rd, 32'd0);
    check("rel_no_cap_z",  {31'd0, bus.z}, 32'd0);
    @(posedge clk); #1;
    check("rel_cap_rd", bus.rd, 32'd0);
    check("rel_cap_z",  {31'd0, bus.z}, 32'd1);

    // Table of single ops
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].funct3, vecs[i].funct7, vecs[i].rs1, vecs[i].rs2);
      @(posedge clk); #1;
      check({vecs[i].name, "_rd"}, bus.rd, vecs[i].exp_rd);
      check({vecs[i].name, "_z"}, {31'd0, bus.z}, {31'd0, vecs[i].exp_z});
    end

    // Back-to-back stream: one op per cycle. Before the edge rd still shows
    // the previous op, and after it rd shows the current one.
    @(negedge clk);
    drive(3'b000, 1'b0, 32'd1, 32'd2);   exp_q.push_back({1'b0, 32'd3});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check("b2b_0", {31'd0, bus.z} ^ {31'd0, e[XLEN]} | (bus.rd ^ e[XLEN-1:0]), 32'd0);
    @(negedge clk);
    drive(3'b000, 1'b0, 32'hFFFFFFFF, 32'd1); exp_q.push_back({1'b1, 32'd0});
    #1;
    check("b2b_hold_prev", bus.rd, 32'd3);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check("b2b_1_rd", bus.rd, e[XLEN-1:0]);
    check("b2b_1_z", {31'd0, bus.z}, {31'd0, e[XLEN]});
    @(negedge clk);
    drive(3'b101, 1'b1, 32'hC0000000, 32'd1); exp_q.push_back({1'b0, 32'hE0000000});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check("b2b_2_rd", bus.rd, e[XLEN-1:0]);
    check("b2b_2_z", {31'd0, bus.z}, {31'd0, e[XLEN]});
    @(negedge clk);
    drive(3'b011, 1'b0, 32'd5, 32'd5);  exp_q.push_back({1'b1, 32'd0});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check("b2b_3_rd", bus.rd, e[XLEN-1:0]);
    check("b2b_3_z", {31'd0, bus.z}, {31'd0, e[XLEN]});

    check("b2b_queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
